// File: rtl/usb2_ep0_xfer.sv
// usb2_ep0_xfer: protocol-side transfer engine for endpoint 0.
// Receives SETUP/OUT data into the EP0 setup buffer, streams the prepared
// IN response out of the EP0 response buffer, and generates handshakes.
module usb2_ep0_xfer #(
   parameter int unsigned MAX_PKT    = 64,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned HS_TIMEOUT = 1023
) (
   input  logic       phy_clk,
   input  logic       reset,
   input  logic [6:0] dev_addr,
   input  logic       rx_pid_valid,
   input  logic [3:0] rx_pid,
   input  logic [6:0] rx_addr,
   input  logic [3:0] rx_endp,
   input  logic [7:0] rx_data,
   input  logic       rx_data_valid,
   input  logic       rx_data_done,
   input  logic       rx_data_err,
   output logic       tx_req,
   output logic [3:0] tx_pid,
   output logic [7:0] tx_data,
   output logic       tx_data_valid,
   input  logic       tx_data_ready,
   output logic       tx_last,
   input  logic       tx_done,
   output logic [8:0] buf_in_addr,
   output logic [7:0] buf_in_data,
   output logic       buf_in_wren,
   input  logic       buf_in_ready,
   output logic       buf_in_commit,
   output logic [9:0] buf_in_commit_len,
   input  logic       buf_in_commit_ack,
   output logic [8:0] buf_out_addr,
   input  logic [7:0] buf_out_q,
   input  logic [9:0] buf_out_len,
   input  logic       buf_out_hasdata,
   output logic       buf_out_arm,
   input  logic       buf_out_arm_ack
);

   localparam logic [3:0] PID_OUT      = 4'h1;
   localparam logic [3:0] PID_IN       = 4'h9;
   localparam logic [3:0] PID_SETUP    = 4'hD;
   localparam logic [3:0] PID_DATA0    = 4'h3;
   localparam logic [3:0] PID_DATA1    = 4'hB;
   localparam logic [3:0] PID_ACK      = 4'h2;
   localparam logic [3:0] PID_NAK      = 4'hA;
   localparam logic [3:0] PID_STALL    = 4'hE;
   localparam logic [3:0] PID_TX_DATA1 = 4'h4;

   localparam logic [9:0]  MAX_LEN = 10'(MAX_PKT);
   localparam logic [15:0] TO_LIM  = 16'(HS_TIMEOUT);
   // One extra stage so capture happens on the cycle after buf_out_q settles.
   localparam int unsigned PIPE    = RD_LAT + 1;

   typedef enum logic [3:0] {
      StIdle, StSetupRx, StCommit, StSendHs, StInFill, StInSend, StInWaitHs, StArm, StOutRx
   } state_t;

   state_t      state_q;
   logic [9:0]  cnt_q;
   logic [15:0] to_cnt_q;
   logic [1:0]  hold_q;
   logic        ack_seen_q;
   logic        rdy_q;
   logic        data_seen_q;
   logic [9:0]  len_q;

   // Prefetch FIFO and read pipeline
   logic [PIPE-1:0] rd_pipe_q;
   logic [7:0]      fifo_mem [4];
   logic [1:0]      wr_ptr_q, rd_ptr_q;
   logic [2:0]      fifo_cnt_q;
   logic [9:0]      rd_addr_q, sent_cnt_q;

   logic       tok_match, pid_is_token, setup_hit, timeout, counting;
   logic       pf_run, issue, capture, pop;
   logic [3:0] inflight;

   // Token decode and prefetch control
   always_comb begin
      tok_match    = rx_pid_valid && (rx_addr == dev_addr) && (rx_endp == 4'd0);
      pid_is_token = (rx_pid[1:0] == 2'b01);
      setup_hit    = tok_match && (rx_pid == PID_SETUP);
      timeout      = (to_cnt_q >= TO_LIM);
      counting     = (state_q == StSetupRx) || (state_q == StInWaitHs) || (state_q == StOutRx);
      pf_run       = (state_q == StInFill) || (state_q == StInSend);
      inflight     = 4'($countones(rd_pipe_q));
      issue        = pf_run && (rd_addr_q < len_q) && (({1'b0, fifo_cnt_q} + inflight) < 4'd4);
      capture      = rd_pipe_q[PIPE-1];
      pop          = tx_data_valid && tx_data_ready;
   end

   // Payload outputs come straight off the FIFO head registers
   always_comb begin
      tx_data_valid = (state_q == StInSend) && (fifo_cnt_q != 3'd0);
      tx_data       = tx_data_valid ? fifo_mem[rd_ptr_q] : 8'h00;
      tx_last       = tx_data_valid && (sent_cnt_q == len_q - 10'd1);
   end

   // Transaction FSM with registered handshake/buffer outputs
   always_ff @(posedge phy_clk) begin
      if (reset) begin
         state_q           <= StIdle;
         cnt_q             <= '0;
         to_cnt_q          <= '0;
         hold_q            <= '0;
         ack_seen_q        <= 1'b0;
         rdy_q             <= 1'b0;
         data_seen_q       <= 1'b0;
         len_q             <= '0;
         tx_req            <= 1'b0;
         tx_pid            <= '0;
         buf_in_addr       <= '0;
         buf_in_data       <= '0;
         buf_in_wren       <= 1'b0;
         buf_in_commit     <= 1'b0;
         buf_in_commit_len <= '0;
         buf_out_arm       <= 1'b0;
      end else begin
         buf_in_wren <= 1'b0;
         to_cnt_q    <= counting ? to_cnt_q + 16'd1 : '0;

         unique case (state_q)
            StIdle: begin
               if (tok_match && rx_pid == PID_IN) begin
                  if (buf_out_hasdata) begin
                     state_q <= StInFill;
                     len_q   <= buf_out_len;
                  end else begin
                     state_q <= StSendHs;
                     tx_req  <= 1'b1;
                     tx_pid  <= PID_NAK;
                  end
               end else if (tok_match && rx_pid == PID_OUT) begin
                  state_q     <= StOutRx;
                  cnt_q       <= '0;
                  data_seen_q <= 1'b0;
               end
            end

            StSetupRx: begin
               if (rx_pid_valid && !pid_is_token) begin
                  if (rx_pid == PID_DATA0) begin
                     data_seen_q <= 1'b1;
                  end else begin
                     state_q  <= StIdle;
                     to_cnt_q <= '0;
                  end
               end else if (rx_data_valid && data_seen_q) begin
                  if (cnt_q != 10'h3FF) cnt_q <= cnt_q + 10'd1;
                  if (rdy_q && cnt_q < MAX_LEN) begin
                     buf_in_wren <= 1'b1;
                     buf_in_addr <= cnt_q[8:0];
                     buf_in_data <= rx_data;
                  end
               end else if (rx_data_done && data_seen_q) begin
                  to_cnt_q <= '0;
                  // Buffer was busy at token time: drop silently, never NAK a SETUP
                  if (rdy_q) begin
                     state_q           <= StCommit;
                     buf_in_commit     <= 1'b1;
                     buf_in_commit_len <= (cnt_q > MAX_LEN) ? MAX_LEN : cnt_q;
                     hold_q            <= '0;
                     ack_seen_q        <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if ((rx_data_err && data_seen_q) || timeout) begin
                  state_q  <= StIdle;
                  to_cnt_q <= '0;
               end
            end

            StCommit: begin
               // EP0 edge-detects commit through two flops: keep it up 3 cycles minimum
               if (hold_q != 2'd3) hold_q <= hold_q + 2'd1;
               if (buf_in_commit_ack) ack_seen_q <= 1'b1;
               if (hold_q >= 2'd2 && (ack_seen_q || buf_in_commit_ack)) begin
                  buf_in_commit     <= 1'b0;
                  buf_in_commit_len <= '0;
                  state_q           <= StSendHs;
                  tx_req            <= 1'b1;
                  tx_pid            <= PID_ACK;
               end
            end

            StSendHs: begin
               if (tx_done) begin
                  tx_req  <= 1'b0;
                  tx_pid  <= '0;
                  state_q <= StIdle;
               end
            end

            StInFill: begin
               if (fifo_cnt_q != 3'd0 || len_q == 10'd0) begin
                  tx_req  <= 1'b1;
                  tx_pid  <= PID_TX_DATA1;
                  state_q <= StInSend;
               end
            end

            StInSend: begin
               if (tx_done) begin
                  tx_req  <= 1'b0;
                  tx_pid  <= '0;
                  state_q <= StInWaitHs;
               end
            end

            StInWaitHs: begin
               if (rx_pid_valid && !pid_is_token) begin
                  to_cnt_q <= '0;
                  if (rx_pid == PID_ACK) begin
                     state_q     <= StArm;
                     buf_out_arm <= 1'b1;
                     hold_q      <= '0;
                     ack_seen_q  <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (timeout) begin
                  // Response stays pending; a retried IN resends it from address 0
                  state_q  <= StIdle;
                  to_cnt_q <= '0;
               end
            end

            StArm: begin
               if (hold_q != 2'd3) hold_q <= hold_q + 2'd1;
               if (buf_out_arm_ack) ack_seen_q <= 1'b1;
               if (hold_q >= 2'd2 && (ack_seen_q || buf_out_arm_ack)) begin
                  buf_out_arm <= 1'b0;
                  state_q     <= StIdle;
               end
            end

            StOutRx: begin
               if (rx_pid_valid && (rx_pid == PID_DATA0 || rx_pid == PID_DATA1)) begin
                  data_seen_q <= 1'b1;
               end else if (rx_data_valid && data_seen_q) begin
                  if (cnt_q != 10'h3FF) cnt_q <= cnt_q + 10'd1;
               end else if (rx_data_done && data_seen_q) begin
                  // Only the two CRC bytes present means a zero-length status packet
                  state_q  <= StSendHs;
                  tx_req   <= 1'b1;
                  tx_pid   <= (cnt_q <= 10'd2) ? PID_ACK : PID_STALL;
                  to_cnt_q <= '0;
               end else if ((rx_data_err && data_seen_q) || timeout) begin
                  state_q  <= StIdle;
                  to_cnt_q <= '0;
               end
            end

            default: state_q <= StIdle;
         endcase

         // A fresh SETUP aborts anything except an in-progress commit or arm
         if (setup_hit && state_q != StCommit && state_q != StArm) begin
            state_q     <= StSetupRx;
            cnt_q       <= '0;
            rdy_q       <= buf_in_ready;
            data_seen_q <= 1'b0;
            to_cnt_q    <= '0;
            tx_req      <= 1'b0;
            tx_pid      <= '0;
         end
      end
   end

   // Prefetch: issue reads RD_LAT ahead, never exceeding four buffered plus in-flight bytes
   always_ff @(posedge phy_clk) begin
      if (reset || !pf_run) begin
         rd_pipe_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
         rd_addr_q    <= '0;
         sent_cnt_q   <= '0;
         buf_out_addr <= '0;
      end else begin
         rd_pipe_q <= {rd_pipe_q[PIPE-2:0], issue};
         if (issue) begin
            buf_out_addr <= rd_addr_q[8:0];
            rd_addr_q    <= rd_addr_q + 10'd1;
         end
         if (capture) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + 2'd1;
            sent_cnt_q <= sent_cnt_q + 10'd1;
         end
         case ({capture, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // FIFO storage needs no reset; head is masked while empty
   always_ff @(posedge phy_clk) begin
      if (capture) fifo_mem[wr_ptr_q] <= buf_out_q;
   end

endmodule

// File: tb/tb_usb2_ep0_xfer.sv
// Directed bench for usb2_ep0_xfer: SETUP/IN/OUT transactions, timeouts, reset.
`timescale 1ns/1ps
module tb_usb2_ep0_xfer;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;

   logic       phy_clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] dev_addr = 7'd0;
   logic       rx_pid_valid = 1'b0;
   logic [3:0] rx_pid = 4'h0;
   logic [6:0] rx_addr = 7'd0;
   logic [3:0] rx_endp = 4'd0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_valid = 1'b0;
   logic       rx_data_done = 1'b0;
   logic       rx_data_err = 1'b0;
   logic       tx_req;
   logic [3:0] tx_pid;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready = 1'b0;
   logic       tx_last;
   logic       tx_done = 1'b0;
   logic [8:0] buf_in_addr;
   logic [7:0] buf_in_data;
   logic       buf_in_wren;
   logic       buf_in_ready = 1'b1;
   logic       buf_in_commit;
   logic [9:0] buf_in_commit_len;
   logic       buf_in_commit_ack = 1'b0;
   logic [8:0] buf_out_addr;
   logic [7:0] buf_out_q;
   logic [9:0] buf_out_len = 10'd0;
   logic       buf_out_hasdata = 1'b0;
   logic       buf_out_arm;
   logic       buf_out_arm_ack = 1'b0;

   int tests = 0;
   int fails = 0;

   usb2_ep0_xfer dut (
      .phy_clk(phy_clk), .reset(reset), .dev_addr(dev_addr),
      .rx_pid_valid(rx_pid_valid), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_done(rx_data_done),
      .rx_data_err(rx_data_err), .tx_req(tx_req), .tx_pid(tx_pid), .tx_data(tx_data),
      .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready), .tx_last(tx_last),
      .tx_done(tx_done), .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
      .buf_in_wren(buf_in_wren), .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
      .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
      .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
      .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
      .buf_out_arm_ack(buf_out_arm_ack)
   );

   always #5 phy_clk = ~phy_clk;

   // Every output concatenated, for all-zero checks
   logic [53:0] all_out;
   assign all_out = {tx_req, tx_pid, tx_data, tx_data_valid, tx_last, buf_in_addr, buf_in_data,
                     buf_in_wren, buf_in_commit, buf_in_commit_len, buf_out_addr, buf_out_arm};

   // Response buffer with a two-cycle read latency
   logic [7:0] ep_mem [0:63];
   logic [7:0] rd_s1;
   always @(posedge phy_clk) begin
      rd_s1     <= ep_mem[buf_out_addr[5:0]];
      buf_out_q <= rd_s1;
   end

   // Event monitor; only this process writes these
   logic [8:0] wr_addr [0:255];
   logic [7:0] wr_data [0:255];
   int wr_n = 0, commit_n = 0, txreq_n = 0, arm_n = 0;
   always @(negedge phy_clk) begin
      if (buf_in_wren) begin
         wr_addr[wr_n] = buf_in_addr;
         wr_data[wr_n] = buf_in_data;
         wr_n++;
      end
      if (buf_in_commit) commit_n++;
      if (tx_req) txreq_n++;
      if (buf_out_arm) arm_n++;
   end

   logic [7:0] spkt [0:9];
   logic [7:0] got [0:127];

   task automatic tick();
      @(negedge phy_clk);
   endtask

   function automatic logic [7:0] pkt_byte(input int i);
      return (i < 10) ? spkt[i] : 8'(i * 3 + 1);
   endfunction

   task automatic send_pid(input logic [3:0] pid, input logic [6:0] addr);
      rx_pid_valid = 1'b1; rx_pid = pid; rx_addr = addr; rx_endp = 4'd0;
      tick();
      rx_pid_valid = 1'b0; rx_pid = 4'h0; rx_addr = 7'd0;
   endtask

   task automatic send_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         rx_data_valid = 1'b1; rx_data = pkt_byte(i);
         tick();
      end
      rx_data_valid = 1'b0;
      rx_data_done = 1'b1;
      tick();
      rx_data_done = 1'b0;
   endtask

   // Transmitter model: collects payload with optional random back-pressure, then tx_done
   task automatic tx_sink(input bit payload, input bit rnd, output logic [3:0] pid,
                          output int nb, output int last_pos, output bit ok);
      bit fin;
      ok = 1'b0; nb = 0; last_pos = -1; pid = 4'h0; fin = 1'b0;
      for (int g = 0; g < 200 && !tx_req; g++) tick();
      if (!tx_req) return;
      pid = tx_pid;
      if (payload) begin
         for (int g = 0; g < 600 && !fin; g++) begin
            tx_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_data_valid && tx_data_ready) begin
               got[nb] = tx_data;
               if (tx_last) begin
                  last_pos = nb;
                  fin = 1'b1;
               end
               nb++;
            end
            tick();
         end
         tx_data_ready = 1'b0;
         if (!fin) return;
      end else if (tx_data_valid) begin
         nb = 1;
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      ok = 1'b1;
   endtask

   // Drives the level handshake: one-cycle ack pulse on the (ack_delay+1)th high cycle
   task automatic do_commit(input int ack_delay, output int hi, output logic [9:0] clen,
                            output bit ok);
      hi = 0; ok = 1'b0; clen = 10'd0;
      for (int g = 0; g < 20 && !buf_in_commit; g++) tick();
      if (!buf_in_commit) return;
      clen = buf_in_commit_len;
      while (buf_in_commit && hi < 50) begin
         hi++;
         buf_in_commit_ack = (hi == ack_delay + 1);
         tick();
      end
      buf_in_commit_ack = 1'b0;
      ok = !buf_in_commit;
   endtask

   task automatic do_arm(input int ack_delay, output int hi, output bit ok);
      hi = 0; ok = 1'b0;
      for (int g = 0; g < 20 && !buf_out_arm; g++) tick();
      if (!buf_out_arm) return;
      while (buf_out_arm && hi < 50) begin
         hi++;
         buf_out_arm_ack = (hi == ack_delay + 1);
         tick();
      end
      buf_out_arm_ack = 1'b0;
      ok = !buf_out_arm;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      tests++;
      if (all_out !== 54'd0) begin
         fails++; $display("FAIL reset_outputs: got %h, want 0", all_out);
      end
      reset = 1'b0;
      repeat (2) tick();
      tests++;
      if (all_out !== 54'd0) begin
         fails++; $display("FAIL idle_outputs: got %h, want 0", all_out);
      end
   endtask

   task automatic test_setup(input int n, input int ack_delay);
      int base, exp_n, exp_hi, hi, nb, lp;
      logic [9:0] clen;
      logic [3:0] pid;
      bit ok;
      base   = wr_n;
      exp_n  = (n > 64) ? 64 : n;
      exp_hi = (ack_delay + 1 > 3) ? ack_delay + 1 : 3;
      buf_in_ready = 1'b1;
      send_pid(PID_SETUP, 7'd0);
      send_pid(PID_DATA0, 7'd0);
      send_bytes(n);
      do_commit(ack_delay, hi, clen, ok);
      tests++;
      if (!ok || hi != exp_hi) begin
         fails++; $display("FAIL setup%0d_commit_hold: ok=%0d cycles=%0d, want 1/%0d", n, ok, hi, exp_hi);
      end
      tests++;
      if (clen !== 10'(exp_n)) begin
         fails++; $display("FAIL setup%0d_commit_len: got %0d, want %0d", n, clen, exp_n);
      end
      tx_sink(1'b0, 1'b0, pid, nb, lp, ok);
      tests++;
      if (!ok || pid !== PID_ACK || nb != 0) begin
         fails++; $display("FAIL setup%0d_handshake: ok=%0d pid=%h bytes=%0d, want 1/2/0", n, ok, pid, nb);
      end
      tick();
      tests++;
      if (wr_n - base != exp_n) begin
         fails++; $display("FAIL setup%0d_wr_count: got %0d, want %0d", n, wr_n - base, exp_n);
      end else begin
         for (int i = 0; i < exp_n; i++) begin
            tests++;
            if (wr_addr[base + i] !== 9'(i) || wr_data[base + i] !== pkt_byte(i)) begin
               fails++;
               $display("FAIL setup%0d_wr[%0d]: got %0d/%h, want %0d/%h", n, i,
                        wr_addr[base + i], wr_data[base + i], i, pkt_byte(i));
            end
         end
      end
   endtask

   task automatic check_in18(input string tag);
      logic [3:0] pid;
      int nb, lp;
      bit ok;
      tx_sink(1'b1, 1'b1, pid, nb, lp, ok);
      tests++;
      if (!ok || pid !== 4'h4 || nb != 18 || lp != 17) begin
         fails++;
         $display("FAIL %s_packet: ok=%0d pid=%h bytes=%0d last=%0d, want 1/4/18/17", tag, ok, pid, nb, lp);
      end else begin
         for (int i = 0; i < 18; i++) begin
            tests++;
            if (got[i] !== ep_mem[i]) begin
               fails++; $display("FAIL %s_byte[%0d]: got %h, want %h", tag, i, got[i], ep_mem[i]);
            end
         end
      end
   endtask

   task automatic test_in_data();
      int hi;
      bit ok;
      buf_out_hasdata = 1'b1; buf_out_len = 10'd18;
      send_pid(PID_IN, 7'd0);
      check_in18("in");
      send_pid(PID_ACK, 7'd0);
      do_arm(2, hi, ok);
      tests++;
      if (!ok || hi != 3) begin
         fails++; $display("FAIL in_arm_hold: ok=%0d cycles=%0d, want 1/3", ok, hi);
      end
      buf_out_hasdata = 1'b0;
      tick();
   endtask

   task automatic test_nak();
      logic [3:0] pid;
      int nb, lp;
      bit ok;
      buf_out_hasdata = 1'b0;
      send_pid(PID_IN, 7'd0);
      tx_sink(1'b0, 1'b0, pid, nb, lp, ok);
      tests++;
      if (!ok || pid !== 4'hA || nb != 0) begin
         fails++; $display("FAIL nak: ok=%0d pid=%h bytes=%0d, want 1/a/0", ok, pid, nb);
      end
      tick();
   endtask

   task automatic test_in_timeout();
      int base, hi;
      bit ok;
      buf_out_hasdata = 1'b1; buf_out_len = 10'd18;
      send_pid(PID_IN, 7'd0);
      check_in18("in_first");
      base = arm_n;
      repeat (1100) tick();
      tests++;
      if (arm_n != base) begin
         fails++; $display("FAIL timeout_no_arm: arm cycles %0d, want 0", arm_n - base);
      end
      send_pid(PID_IN, 7'd0);
      check_in18("in_retry");
      send_pid(PID_ACK, 7'd0);
      do_arm(0, hi, ok);
      tests++;
      if (!ok || hi != 3) begin
         fails++; $display("FAIL retry_arm_hold: ok=%0d cycles=%0d, want 1/3", ok, hi);
      end
      buf_out_hasdata = 1'b0;
      tick();
   endtask

   task automatic test_out();
      logic [3:0] pid;
      int nb, lp;
      bit ok;
      // Zero-length DATA1 carries only its two CRC bytes
      send_pid(PID_OUT, 7'd0);
      send_pid(PID_DATA1, 7'd0);
      send_bytes(2);
      tx_sink(1'b0, 1'b0, pid, nb, lp, ok);
      tests++;
      if (!ok || pid !== 4'h2) begin
         fails++; $display("FAIL out_zlp: ok=%0d pid=%h, want 1/2", ok, pid);
      end
      tick();
      send_pid(PID_OUT, 7'd0);
      send_pid(PID_DATA1, 7'd0);
      send_bytes(5);
      tx_sink(1'b0, 1'b0, pid, nb, lp, ok);
      tests++;
      if (!ok || pid !== 4'hE) begin
         fails++; $display("FAIL out_3byte: ok=%0d pid=%h, want 1/e", ok, pid);
      end
      tick();
   endtask

   task automatic test_setup_ignored(input string tag, input logic [6:0] addr, input logic rdy);
      int wb, cb, tb;
      wb = wr_n; cb = commit_n; tb = txreq_n;
      buf_in_ready = rdy;
      send_pid(PID_SETUP, addr);
      send_pid(PID_DATA0, 7'd0);
      send_bytes(10);
      repeat (20) tick();
      tests++;
      if (wr_n != wb || commit_n != cb || txreq_n != tb) begin
         fails++;
         $display("FAIL %s: wren=%0d commit=%0d tx_req=%0d cycles, want 0/0/0", tag,
                  wr_n - wb, commit_n - cb, txreq_n - tb);
      end
      buf_in_ready = 1'b1;
   endtask

   task automatic test_reset_mid_commit();
      send_pid(PID_SETUP, 7'd0);
      send_pid(PID_DATA0, 7'd0);
      send_bytes(10);
      for (int g = 0; g < 20 && !buf_in_commit; g++) tick();
      repeat (2) tick();
      tests++;
      if (buf_in_commit !== 1'b1) begin
         fails++; $display("FAIL rst_commit_held: got %b, want 1", buf_in_commit);
      end
      reset = 1'b1;
      tick();
      tests++;
      if (buf_in_commit !== 1'b0) begin
         fails++; $display("FAIL rst_commit_drop: got %b, want 0", buf_in_commit);
      end
      tests++;
      if (all_out !== 54'd0) begin
         fails++; $display("FAIL rst_mid_outputs: got %h, want 0", all_out);
      end
      reset = 1'b0;
      tick();
      test_setup(10, 0);
   endtask

   initial begin
      spkt = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00, 8'h94, 8'hF4};
      for (int i = 0; i < 64; i++) ep_mem[i] = 8'(i * 7 + 8'h35);
      test_reset();
      test_setup(10, 4);
      test_in_data();
      test_nak();
      test_in_timeout();
      test_out();
      test_setup_ignored("setup_not_ready", 7'd0, 1'b0);
      test_setup_ignored("setup_wrong_addr", 7'd5, 1'b1);
      test_setup(70, 0);
      test_reset_mid_commit();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
